rst_seq_sync: RTL



---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/rst_seq_sync_if.sv | 25 ++
 rtl/rst_sync_core.sv | 25 ++
 rtl/rst_seq_sync.sv | 117 +++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        StSync,
        StHold,
        StRelease,
        StDone,
        StSwrst
    } seq_state_e;

    // Width needed to hold the largest of the three reload values.
    function automatic int unsigned cnt_w(input int unsigned hold,
                                          input int unsigned gap,
                                          input int unsigned pulse);
        int unsigned m;
        m = hold;
        if (gap > m) m = gap;
        if (pulse > m) m = pulse;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_sync_if.sv
// Sequenced-reset bundle: software request in, per-channel resets and status out.
interface rst_seq_sync_if #(
    parameter int unsigned NUM_CH = 4
) ();

    logic              sw_rst_req;
    logic [NUM_CH-1:0] rst_n_out;
    logic              busy;
    logic              seq_done;

    modport master (
        output sw_rst_req,
        input  rst_n_out,
        input  busy,
        input  seq_done
    );

    modport slave (
        input  sw_rst_req,
        output rst_n_out,
        output busy,
        output seq_done
    );

endinterface

// File: rtl/rst_sync_core.sv
// Async-assert / sync-deassert reset synchronizer chain.
module rst_sync_core #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_synced,
    output logic release_next
);

    (* async_reg = "true" *) logic [NUM_STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[NUM_STAGES-2:0], 1'b1};
        end
    end

    assign rst_synced   = ~chain_q[NUM_STAGES-1];
    // Input of the last stage: high means the synced reset drops on the coming edge.
    assign release_next = chain_q[NUM_STAGES-2];

endmodule

// File: rtl/rst_seq_sync.sv
// Reset synchronizer plus sequencer: releases NUM_CH active-low resets in order after a hold,
// and re-runs the hold/release sequence on a software request.
module rst_seq_sync
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 2,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 3,
    parameter int unsigned SW_PULSE    = 8
) (
    input  logic           clk,
    input  logic           rst,
    rst_seq_sync_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_w(HOLD_CYCLES, GAP_CYCLES, SW_PULSE);
    localparam int unsigned CH_W  = $clog2(NUM_CH + 1);

    logic              rst_synced;
    logic              release_next;
    seq_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CH_W-1:0]   ch_q;
    logic [NUM_CH-1:0] rst_n_q;
    logic              busy_q;
    logic              done_q;

    rst_sync_core #(
        .NUM_STAGES (NUM_STAGES)
    ) u_sync (
        .clk          (clk),
        .rst          (rst),
        .rst_synced   (rst_synced),
        .release_next (release_next)
    );

    // The state register captures the chain in parallel with its last stage, so HOLD is
    // entered on the same edge the synchronized reset deasserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StSync;
            cnt_q   <= '0;
            ch_q    <= '0;
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StSync: begin
                    if (rst_synced && release_next) begin
                        state_q <= StHold;
                        cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        rst_n_q[0] <= 1'b1;
                        if (NUM_CH == 1) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRelease;
                            ch_q    <= CH_W'(1);
                            cnt_q   <= CNT_W'(GAP_CYCLES - 1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StRelease: begin
                    if (cnt_q == '0) begin
                        for (int unsigned k = 0; k < NUM_CH; k++) begin
                            if (ch_q == CH_W'(k)) rst_n_q[k] <= 1'b1;
                        end
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            ch_q  <= ch_q + CH_W'(1);
                            cnt_q <= CNT_W'(GAP_CYCLES - 1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StDone: begin
                    if (bus.sw_rst_req) begin
                        state_q <= StSwrst;
                        rst_n_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        cnt_q   <= CNT_W'(SW_PULSE - 1);
                    end
                end
                StSwrst: begin
                    if (cnt_q == '0) begin
                        state_q <= StHold;
                        cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StSync;
                end
            endcase
        end
    end

    assign bus.rst_n_out = rst_n_q;
    assign bus.busy      = busy_q;
    assign bus.seq_done  = done_q;

endmodule
